// File: rtl/microsequencer_if.sv
// Sequencing bus between the microstore/control register, encoder, condition tester and the microsequencer.
// The control side uses the master modport; the sequencer uses slave.
interface microsequencer_if;
  logic [2:0] ns_sel;
  logic [9:0] cr_addr;
  logic       inv;
  logic       cond;
  logic       moc;
  logic [9:0] enc_state;
  logic       stall;
  logic [9:0] next_state;
  logic [9:0] state_q;
  logic       useq_err;

  modport master (
    output ns_sel, cr_addr, inv, cond, moc, enc_state, stall,
    input  next_state, state_q, useq_err
  );

  modport slave (
    input  ns_sel, cr_addr, inv, cond, moc, enc_state, stall,
    output next_state, state_q, useq_err
  );
endinterface

// File: rtl/microsequencer.sv
// Next microstore address selection for the control unit; MICRO_STACK_EN adds a micro call/return stack.
// next_state is combinational, state_q follows one clock later; stall freezes state, stack and error flag.
module microsequencer #(
  parameter int NUM_STATES  = 50,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  microsequencer_if.slave bus
);
  localparam logic [2:0] SEL_DISPATCH = 3'b000;
  localparam logic [2:0] SEL_INCR     = 3'b001;
  localparam logic [2:0] SEL_JUMP     = 3'b010;
  localparam logic [2:0] SEL_BRANCH   = 3'b011;
  localparam logic [2:0] SEL_WAIT     = 3'b100;
  localparam logic [2:0] SEL_CALL     = 3'b101;
  localparam logic [2:0] SEL_RETURN   = 3'b110;
  localparam logic [10:0] LIMIT       = 11'(NUM_STATES);

  if (STACK_DEPTH < 2) begin : g_bad_depth
    $error("microsequencer: STACK_DEPTH must be at least 2");
  end

  logic [9:0]  state_q;
  logic [9:0]  next_state;
  logic        useq_err;
  logic [10:0] sel_addr;
  logic [10:0] incr_addr;
  logic        sel_err;
  logic        range_err;
  logic        err_now;
  logic        t_cond;
  logic        m_cond;

  assign t_cond    = bus.cond ^ bus.inv;
  assign m_cond    = bus.moc ^ bus.inv;
  // One extra bit so an increment past the top can never wrap into a legal address.
  assign incr_addr = {1'b0, state_q} + 11'd1;

`ifdef MICRO_STACK_EN
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [9:0]      stack_mem [STACK_DEPTH];
  logic [SP_W-1:0] sp_q;
  logic            stack_full;
  logic            stack_empty;
  logic [9:0]      stack_top;
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] top_idx;
  logic            push;
  logic            pop;

  assign stack_full  = (sp_q == SP_FULL);
  assign stack_empty = (sp_q == '0);
  assign push_idx    = IDX_W'(sp_q);
  assign top_idx     = IDX_W'(sp_q - SP_W'(1));
  assign stack_top   = stack_mem[top_idx];
`endif

  // Next-state selection from the sequencing fields.
  always_comb begin : p_next_sel
    sel_addr = '0;
    sel_err  = 1'b0;
`ifdef MICRO_STACK_EN
    push     = 1'b0;
    pop      = 1'b0;
`endif
    case (bus.ns_sel)
      SEL_DISPATCH: sel_addr = {1'b0, bus.enc_state};
      SEL_INCR:     sel_addr = incr_addr;
      SEL_JUMP:     sel_addr = {1'b0, bus.cr_addr};
      SEL_BRANCH:   sel_addr = t_cond ? {1'b0, bus.cr_addr} : incr_addr;
      SEL_WAIT:     sel_addr = m_cond ? incr_addr : {1'b0, state_q};
      SEL_CALL: begin
        sel_addr = {1'b0, bus.cr_addr};
`ifdef MICRO_STACK_EN
        // A call into a full stack still jumps; only the return address is lost.
        if (stack_full) sel_err = 1'b1;
        else            push    = 1'b1;
`endif
      end
      SEL_RETURN: begin
`ifdef MICRO_STACK_EN
        if (stack_empty) begin
          sel_err = 1'b1;
        end else begin
          pop      = 1'b1;
          sel_addr = {1'b0, stack_top};
        end
`else
        sel_err = 1'b1;
`endif
      end
      default: sel_addr = '0;
    endcase
    range_err = (sel_addr >= LIMIT);
  end

  // Output: reset forces 0, stall holds, illegal targets restart at 0.
  always_comb begin : p_output
    next_state = sel_addr[9:0];
    err_now    = 1'b0;
    if (!reset_n) begin
      next_state = '0;
    end else if (bus.stall) begin
      next_state = state_q;
    end else begin
      if (range_err) next_state = '0;
      err_now = sel_err | range_err;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : p_state_reg
    if (!reset_n) begin
      state_q  <= '0;
      useq_err <= 1'b0;
    end else if (!bus.stall) begin
      state_q <= next_state;
      if (err_now) useq_err <= 1'b1;
    end
  end

`ifdef MICRO_STACK_EN
  always_ff @(posedge clk or negedge reset_n) begin : p_stack_ptr
    if (!reset_n) begin
      sp_q <= '0;
    end else if (!bus.stall) begin
      if (push)     sp_q <= sp_q + SP_W'(1);
      else if (pop) sp_q <= sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin : p_stack_mem
    if (reset_n && !bus.stall && push) stack_mem[push_idx] <= incr_addr[9:0];
  end
`endif

  assign bus.next_state = next_state;
  assign bus.state_q    = state_q;
  assign bus.useq_err   = useq_err;
endmodule

// File: tb/tb_microsequencer.sv
// Scoreboard bench for the microsequencer: expectations queued at drive time, compared after the clock edge.
module tb_microsequencer;
  localparam logic [2:0] DISP = 3'b000, INCR = 3'b001, JUMP = 3'b010, BRAN = 3'b011;
  localparam logic [2:0] WAIT = 3'b100, CALL = 3'b101, RETN = 3'b110, RSTR = 3'b111;

  typedef struct packed {
    logic [9:0] ns;
    logic [9:0] sq;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  microsequencer_if bus();

  microsequencer #(.NUM_STATES(50), .STACK_DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One sequencing cycle: drive on the falling edge, sample next_state before the
  // rising edge, then compare state_q/useq_err after it against the queued entry.
  task automatic step(input string tag, input logic [2:0] sel, input logic [9:0] cr,
                      input logic iv, input logic cd, input logic mc, input logic [9:0] enc,
                      input logic st, input logic [9:0] e_ns, input logic [9:0] e_sq,
                      input logic e_err);
    exp_t e;
    logic [9:0] obs_ns;
    @(negedge clk);
    bus.ns_sel = sel; bus.cr_addr = cr; bus.inv = iv; bus.cond = cd;
    bus.moc = mc; bus.enc_state = enc; bus.stall = st;
    e.ns = e_ns; e.sq = e_sq; e.err = e_err;
    exp_q.push_back(e);
    #1 obs_ns = bus.next_state;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "/queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "/next_state"}, obs_ns, e.ns);
      chk({tag, "/state_q"}, bus.state_q, e.sq);
      chk({tag, "/useq_err"}, bus.useq_err, e.err);
    end
  endtask

  // Reset asserted away from any clock edge must clear state at once.
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk({tag, "/state_q"}, bus.state_q, 0);
    chk({tag, "/next_state"}, bus.next_state, 0);
    chk({tag, "/useq_err"}, bus.useq_err, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ns_sel = JUMP; bus.cr_addr = 10'd5; bus.inv = 1'b0; bus.cond = 1'b0;
    bus.moc = 1'b0; bus.enc_state = 10'd0; bus.stall = 1'b0;
    #3;
    chk("reset/state_q", bus.state_q, 0);
    chk("reset/next_state", bus.next_state, 0);
    chk("reset/useq_err", bus.useq_err, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    step("incr0", INCR, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("incr1", INCR, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    step("incr2", INCR, 0, 0, 0, 0, 0, 0, 3, 3, 0);
    reset_pulse("async_rst_at3");

    step("incr0b", INCR, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step("incr1b", INCR, 0, 0, 0, 0, 0, 0, 2, 2, 0);
    step("incr2b", INCR, 0, 0, 0, 0, 0, 0, 3, 3, 0);
    for (int i = 0; i < 3; i++)
      step("wait_nomoc", WAIT, 0, 0, 0, 0, 0, 0, 3, 3, 0);
    step("wait_moc", WAIT, 0, 0, 0, 1, 0, 0, 4, 4, 0);
    step("jump3", JUMP, 3, 0, 0, 0, 0, 0, 3, 3, 0);
    for (int i = 0; i < 2; i++)
      step("wait_inv_moc1", WAIT, 0, 1, 0, 1, 0, 0, 3, 3, 0);
    step("wait_inv_moc0", WAIT, 0, 1, 0, 0, 0, 0, 4, 4, 0);
    step("dispatch20", DISP, 0, 0, 0, 0, 20, 0, 20, 20, 0);
    step("jump30", JUMP, 30, 0, 0, 0, 0, 0, 30, 30, 0);
    step("branch_taken", BRAN, 40, 0, 1, 0, 0, 0, 40, 40, 0);
    step("jump30b", JUMP, 30, 0, 0, 0, 0, 0, 30, 30, 0);
    step("branch_inv", BRAN, 40, 1, 1, 0, 0, 0, 31, 31, 0);
    step("jump30c", JUMP, 30, 0, 0, 0, 0, 0, 30, 30, 0);
    step("branch_stall", BRAN, 40, 0, 1, 0, 0, 1, 30, 30, 0);
    step("branch_nt", BRAN, 40, 0, 0, 0, 0, 0, 31, 31, 0);
    step("stall_err", DISP, 0, 0, 0, 0, 60, 1, 31, 31, 0);
    step("jump49", JUMP, 49, 0, 0, 0, 0, 0, 49, 49, 0);
    step("incr_top", INCR, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`ifndef MICRO_STACK_EN
    step("call_as_jump", CALL, 22, 0, 0, 0, 0, 0, 22, 22, 1);
`endif
    step("restart_sticky", RSTR, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    reset_pulse("rst_b");
    step("dispatch60", DISP, 0, 0, 0, 0, 60, 0, 0, 0, 1);
    reset_pulse("rst_c");
    step("jump50", JUMP, 50, 0, 0, 0, 0, 0, 0, 0, 1);
    reset_pulse("rst_d");

`ifdef MICRO_STACK_EN
    step("jump10", JUMP, 10, 0, 0, 0, 0, 0, 10, 10, 0);
    step("call41", CALL, 41, 0, 0, 0, 0, 0, 41, 41, 0);
    step("ret11", RETN, 0, 0, 0, 0, 0, 0, 11, 11, 0);
    step("call20", CALL, 20, 0, 0, 0, 0, 0, 20, 20, 0);
    step("call21", CALL, 21, 0, 0, 0, 0, 0, 21, 21, 0);
    step("call22", CALL, 22, 0, 0, 0, 0, 0, 22, 22, 0);
    step("call23", CALL, 23, 0, 0, 0, 0, 0, 23, 23, 0);
    step("call_full", CALL, 24, 0, 0, 0, 0, 0, 24, 24, 1);
    step("ret23", RETN, 0, 0, 0, 0, 0, 0, 23, 23, 1);
    step("ret22", RETN, 0, 0, 0, 0, 0, 0, 22, 22, 1);
    step("ret21", RETN, 0, 0, 0, 0, 0, 0, 21, 21, 1);
    step("ret12", RETN, 0, 0, 0, 0, 0, 0, 12, 12, 1);
    step("ret_empty_a", RETN, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    reset_pulse("rst_e");
    step("ret_empty_b", RETN, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`else
    step("jump7", JUMP, 7, 0, 0, 0, 0, 0, 7, 7, 0);
    step("ret_as_restart", RETN, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Next-state logic for the microprogrammed control unit.
- Holds the current control-unit state and computes the 10-bit next_state address that indexes the microstore each cycle.
- Chooses that address from the microinstruction's sequencing fields: increment, jump, decode dispatch, conditional branch, wait-on-MOC, optional call/return.
- Sits between the microstore output/control register, the instruction encoder and the condition tester.

Parameters:
- NUM_STATES, 50, number of valid microstore states; legal addresses are 0..NUM_STATES-1.
- STACK_DEPTH, 4, micro-return stack entries; used only with MICRO_STACK_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ns_sel  input  3  sequencing select from the current microinstruction.
- cr_addr  input  10  target state field from the current microinstruction.
- inv  input  1  inverts the tested condition or MOC.
- cond  input  1  condition-tester result.
- moc  input  1  memory operation complete.
- enc_state  input  10  dispatch state from the instruction encoder.
- stall  input  1  holds the current state; no sequencing action.
- next_state  output  10  address to the microstore (combinational).
- state_q  output  10  registered current state.
- useq_err  output  1  sticky error flag.

Behaviour:
- Reset (reset_n=0, async): state_q=0, useq_err=0, stack pointer=0; next_state forced to 0 while reset_n=0.
- Each rising clk with stall=0: state_q <= next_state. With stall=1: state_q holds, no stack change, next_state=state_q.
- ns_sel decode, with t = cond^inv and m = moc^inv:
  - 000 DISPATCH: enc_state.
  - 001 INCR: state_q+1.
  - 010 JUMP: cr_addr.
  - 011 BRANCH: t ? cr_addr : state_q+1.
  - 100 WAIT: m ? state_q+1 : state_q, i.e. stays until MOC.
  - 101 CALL: push state_q+1, go to cr_addr.
  - 110 RETURN: pop, go to popped value.
  - 111 RESTART: 0.
- Latency: next_state is combinational from state_q and the inputs; it becomes state_q one clock later.
- Range check applies to the selected address. Any selected address >= NUM_STATES forces next_state=0 and sets useq_err on that clock edge (stall=0). Example: INCR from NUM_STATES-1.
- useq_err clears only on reset.
- Unused state slots are not checked; zero-filled slots are legal targets.
- Simultaneous stall and error: stall wins, no error latched.

Optional Feature:
- Macro: MICRO_STACK_EN.
- Defined:
  - STACK_DEPTH x 10-bit LIFO.
  - CALL when full: jump still taken, push dropped, useq_err set.
  - RETURN when empty: next_state=0, useq_err set.
  - RETURN of an out-of-range value: treated by the range check.
- Undefined:
  - No stack storage.
  - CALL behaves as JUMP.
  - RETURN behaves as RESTART and sets useq_err.

Test Plan:
- Reset release → state_q=0, next_state=0, useq_err=0. Assert reset_n low mid-sequence at state 3 → state_q=0 immediately, without waiting for clk.
- INCR 0→1→2, then WAIT at state 3 with inv=0 and moc=0 for 3 cycles → state_q stays 3; moc=1 → 4. Repeat with inv=1 and moc=1 → holds; moc=0 → 4.
- State 4 DISPATCH with enc_state=20 → 20. enc_state=60 (>=50) → next_state=0, useq_err=1.
- BRANCH at state 30, cr_addr=40: cond=1 inv=0 → 40; cond=1 inv=1 → 31. stall=1 during branch → state_q stays 30.
- MICRO_STACK_EN: at state 10, CALL cr_addr=41 → 41. Then RETURN → 11. 5 nested CALLs with STACK_DEPTH=4 → 5th sets useq_err. RETURN on empty stack → 0, useq_err=1.
- INCR at state 49 → next_state=0, useq_err=1; without MICRO_STACK_EN, CALL cr_addr=22 → 22 with no later return.
